epc_reg_bridge: RTL and testbench



---
 rtl/epc_reg_bridge_if.sv | 23 ++
 rtl/epc_reg_bridge.sv | 119 +++++++++++
 tb/tb_epc_reg_bridge.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/epc_reg_bridge_if.sv
// EPC-side bus between the PS AXI-EPC pins (master) and a fabric register bridge (slave).
// Bit 0 is the MS bit on every vector, matching the EPC_INTF_* pin numbering.
interface epc_reg_bridge_if;
    logic        epc_cs_n;
    logic        epc_rnw;
    logic        epc_rd_n;
    logic        epc_wr_n;
    logic [0:3]  epc_be;
    logic [0:31] epc_addr;
    logic [0:31] epc_data_i;
    logic [0:31] epc_data_o;
    logic        epc_rdy;

    modport master (
        output epc_cs_n, epc_rnw, epc_rd_n, epc_wr_n, epc_be, epc_addr, epc_data_i,
        input  epc_data_o, epc_rdy
    );

    modport slave (
        input  epc_cs_n, epc_rnw, epc_rd_n, epc_wr_n, epc_be, epc_addr, epc_data_i,
        output epc_data_o, epc_rdy
    );
endinterface

// File: rtl/epc_reg_bridge.sv
// EPC chip-select slave -> single-cycle register bus bridge for the clock/NTP register bank.
// Optional read-wait timeout enabled by defining EPC_TIMEOUT_EN.
module epc_reg_bridge #(
    parameter int          AW             = 8,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    epc_reg_bridge_if.slave   epc,
    output logic [AW-1:0]     reg_addr,
    output logic [31:0]       reg_wdata,
    output logic [3:0]        reg_be,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [31:0]       reg_rdata,
    input  logic              reg_rvalid,
    output logic              timeout_err
);
    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, ACK, HOLD} state_t;

    state_t state, state_nxt;
    logic   wr_start, rd_start, bus_idle, data_load, timeout_hit;

    // A start needs exactly the strobe that matches rnw; both strobes low is a bus error.
    assign wr_start = !epc.epc_cs_n && !epc.epc_rnw && !epc.epc_wr_n &&  epc.epc_rd_n;
    assign rd_start = !epc.epc_cs_n &&  epc.epc_rnw && !epc.epc_rd_n &&  epc.epc_wr_n;
    assign bus_idle =  epc.epc_cs_n || (epc.epc_rd_n && epc.epc_wr_n);

    assign data_load = reg_rvalid && (state == RD_REQ || state == RD_WAIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        reg_wr      = 1'b0;
        reg_rd      = 1'b0;
        epc.epc_rdy = 1'b0;
        case (state)
            IDLE: begin
                if (wr_start)      state_nxt = WR;
                else if (rd_start) state_nxt = RD_REQ;
            end
            WR: begin
                reg_wr    = 1'b1;
                state_nxt = ACK;
            end
            RD_REQ: begin
                reg_rd    = 1'b1;
                state_nxt = reg_rvalid ? ACK : RD_WAIT;
            end
            RD_WAIT: begin
                if (reg_rvalid || timeout_hit) state_nxt = ACK;
            end
            ACK: begin
                epc.epc_rdy = 1'b1;
                state_nxt   = HOLD;
            end
            HOLD: begin
                // Held strobes park here so one CPU access never becomes two.
                if (bus_idle) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ascending EPC vectors land MSB-first in the descending register-bus vectors,
    // so reg_wdata[31-i] = epc_data_i[i] and reg_be[3-k] = epc_be[k] fall out of plain copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_addr       <= '0;
            reg_wdata      <= '0;
            reg_be         <= '0;
            epc.epc_data_o <= '0;
        end else begin
            if (state == IDLE && (wr_start || rd_start)) begin
                reg_addr  <= epc.epc_addr[30-AW:29];
                reg_wdata <= epc.epc_data_i;
                reg_be    <= epc.epc_be;
            end
            if (data_load)        epc.epc_data_o <= reg_rdata;
            else if (timeout_hit) epc.epc_data_o <= TIMEOUT_DATA;
        end
    end

`ifdef EPC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    // wait_cnt counts completed RD_WAIT cycles; it sits at zero outside RD_WAIT.
    assign timeout_hit = (state == RD_WAIT) && !reg_rvalid &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == RD_WAIT) wait_cnt <= wait_cnt + 1'b1;
            else                  wait_cnt <= '0;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Address bits outside the word window are decoded upstream by cs_n.
    logic unused_addr;
    assign unused_addr = ^{epc.epc_addr[0:29-AW], epc.epc_addr[30:31]};

endmodule

// File: tb/tb_epc_reg_bridge.sv
// Directed bench for epc_reg_bridge: writes, reads, held strobes, illegal strobes, reset abort, read wait.
// Define EPC_TIMEOUT_EN at compile time to exercise the read-wait timeout path.
module tb_epc_reg_bridge;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [AW-1:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic        reg_wr, reg_rd;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    int n_wr   = 0;
    int n_rd   = 0;
    int n_rdy  = 0;

    epc_reg_bridge_if bus ();

    epc_reg_bridge #(.AW(AW), .TIMEOUT_CYCLES(16), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
        .clk         (clk),
        .rst         (rst),
        .epc         (bus.slave),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_be      (reg_be),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Pulse counters see the values settled through the previous cycle.
    always @(posedge clk) begin
        if (reg_wr)      n_wr  <= n_wr + 1;
        if (reg_rd)      n_rd  <= n_rd + 1;
        if (bus.epc_rdy) n_rdy <= n_rdy + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.epc_cs_n = 1'b1;
        bus.epc_rnw  = 1'b0;
        bus.epc_rd_n = 1'b1;
        bus.epc_wr_n = 1'b1;
    endtask

    // Data is placed index-for-index: epc_data_i[i] = d[i].
    task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.epc_cs_n = 1'b0;
        bus.epc_rnw  = 1'b0;
        bus.epc_rd_n = 1'b1;
        bus.epc_wr_n = 1'b0;
        bus.epc_addr = a;
        bus.epc_be   = be;
        for (int i = 0; i < 32; i++) bus.epc_data_i[i] = d[i];
    endtask

    task automatic start_rd(input logic [31:0] a);
        bus.epc_cs_n = 1'b0;
        bus.epc_rnw  = 1'b1;
        bus.epc_rd_n = 1'b0;
        bus.epc_wr_n = 1'b1;
        bus.epc_addr = a;
    endtask

    initial begin
        int w0, r0, q0, k;
        rst        = 1'b1;
        reg_rvalid = 1'b0;
        reg_rdata  = '0;
        bus.epc_addr   = '0;
        bus.epc_be     = '0;
        bus.epc_data_i = '0;
        bus_idle();
        repeat (3) tick();
        chk("rst_wr",   32'(reg_wr), 32'd0);
        chk("rst_rd",   32'(reg_rd), 32'd0);
        chk("rst_rdy",  32'(bus.epc_rdy), 32'd0);
        chk("rst_data", bus.epc_data_o, 32'd0);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_wdat", reg_wdata, 32'd0);
        chk("rst_be",   32'(reg_be), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick();

        // Basic write: reg_wr one cycle after start, rdy one cycle later.
        w0 = n_wr; r0 = n_rdy;
        start_wr(32'h0000_0010, 32'h1234_5678, 4'b1111);
        tick();
        chk("wr_pulse", 32'(reg_wr), 32'd1);
        chk("wr_addr",  32'(reg_addr), 32'd4);
        chk("wr_wdata", reg_wdata, 32'h1E6A_2C48);
        chk("wr_be",    32'(reg_be), 32'hF);
        chk("wr_rdy0",  32'(bus.epc_rdy), 32'd0);
        tick();
        chk("wr_rdy1",  32'(bus.epc_rdy), 32'd1);
        chk("wr_wr0",   32'(reg_wr), 32'd0);
        tick();
        chk("wr_rdy2",  32'(bus.epc_rdy), 32'd0);
        bus_idle();
        tick();
        chk("wr_cnt",   32'(n_wr - w0), 32'd1);
        chk("wr_rdyc",  32'(n_rdy - r0), 32'd1);

        // Address bits outside the word window, partial byte enables.
        start_wr(32'h1234_0A5C, 32'h0000_00FF, 4'b0011);
        tick();
        chk("wr2_addr",  32'(reg_addr), 32'h97);
        chk("wr2_wdata", reg_wdata, 32'hFF00_0000);
        chk("wr2_be",    32'(reg_be), 32'h3);
        tick(); tick();
        bus_idle();
        tick();

        // Read with rvalid three cycles after reg_rd.
        q0 = n_rd; r0 = n_rdy;
        start_rd(32'h0000_0020);
        tick();
        chk("rd_pulse", 32'(reg_rd), 32'd1);
        chk("rd_addr",  32'(reg_addr), 32'd8);
        tick();
        chk("rd_rd0",   32'(reg_rd), 32'd0);
        chk("rd_wait0", 32'(bus.epc_rdy), 32'd0);
        tick();
        chk("rd_wait1", 32'(bus.epc_rdy), 32'd0);
        tick();
        reg_rvalid = 1'b1;
        reg_rdata  = 32'h0000_0001;
        tick();
        reg_rvalid = 1'b0;
        chk("rd_rdy",   32'(bus.epc_rdy), 32'd1);
        chk("rd_data",  bus.epc_data_o, 32'h0000_0001);
        chk("rd_bit31", 32'(bus.epc_data_o[31]), 32'd1);
        tick();
        chk("rd_rdy0",  32'(bus.epc_rdy), 32'd0);
        chk("rd_hold",  bus.epc_data_o, 32'h0000_0001);
        bus_idle();
        tick();
        chk("rd_cnt",   32'(n_rd - q0), 32'd1);
        chk("rd_rdyc",  32'(n_rdy - r0), 32'd1);

        // rvalid in the same cycle as reg_rd.
        start_rd(32'h0000_03FC);
        tick();
        chk("rd0_addr", 32'(reg_addr), 32'hFF);
        reg_rvalid = 1'b1;
        reg_rdata  = 32'hF000_0000;
        tick();
        reg_rvalid = 1'b0;
        chk("rd0_rdy",  32'(bus.epc_rdy), 32'd1);
        chk("rd0_data", bus.epc_data_o, 32'hF000_0000);
        tick();
        bus_idle();
        tick();

        // Held write strobe: one transfer only, re-arm after one high cycle.
        w0 = n_wr; r0 = n_rdy;
        start_wr(32'h0000_0004, 32'hA5A5_0000, 4'hF);
        tick(); tick();
        repeat (10) tick();
        chk("held_wr",   32'(n_wr - w0), 32'd1);
        chk("held_rdy",  32'(n_rdy - r0), 32'd1);
        chk("held_data", bus.epc_data_o, 32'hF000_0000);
        bus.epc_wr_n = 1'b1;
        tick();
        start_wr(32'h0000_0008, 32'h0, 4'hF);
        tick();
        chk("rearm_wr",   32'(reg_wr), 32'd1);
        chk("rearm_addr", 32'(reg_addr), 32'd2);
        tick(); tick();
        bus_idle();
        tick();

        // Mismatched / doubled strobes and stray rvalid are ignored.
        w0 = n_wr; q0 = n_rd; r0 = n_rdy;
        reg_rvalid = 1'b1;
        reg_rdata  = 32'h0000_1234;
        bus.epc_cs_n = 1'b0; bus.epc_rnw = 1'b1; bus.epc_wr_n = 1'b0; bus.epc_rd_n = 1'b1;
        repeat (3) tick();
        bus.epc_rd_n = 1'b0;
        repeat (3) tick();
        bus.epc_rnw = 1'b0;
        repeat (2) tick();
        bus.epc_cs_n = 1'b1; bus.epc_rnw = 1'b1; bus.epc_wr_n = 1'b1;
        repeat (2) tick();
        bus_idle();
        reg_rvalid = 1'b0;
        tick();
        chk("ign_wr",   32'(n_wr - w0), 32'd0);
        chk("ign_rd",   32'(n_rd - q0), 32'd0);
        chk("ign_rdy",  32'(n_rdy - r0), 32'd0);
        chk("ign_data", bus.epc_data_o, 32'hF000_0000);

        // Reset while in RD_WAIT aborts; late rvalid is ignored.
        r0 = n_rdy;
        start_rd(32'h0000_0040);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rstw_rdy",  32'(bus.epc_rdy), 32'd0);
        chk("rstw_data", bus.epc_data_o, 32'd0);
        chk("rstw_addr", 32'(reg_addr), 32'd0);
        rst = 1'b0;
        bus_idle();
        reg_rvalid = 1'b1;
        reg_rdata  = 32'h0000_0055;
        tick();
        reg_rvalid = 1'b0;
        tick();
        chk("rstw_late", bus.epc_data_o, 32'd0);
        chk("rstw_rdyc", 32'(n_rdy - r0), 32'd0);

`ifdef EPC_TIMEOUT_EN
        // 16 RD_WAIT cycles with no rvalid, then ACK.
        start_rd(32'h0000_0000);
        tick();
        k = 0;
        while (k < 40 && !bus.epc_rdy) begin
            tick();
            k++;
        end
        chk("to_lat",  32'(k), 32'd17);
        chk("to_data", bus.epc_data_o, 32'hDEAD_BEEF);
        chk("to_err",  32'(timeout_err), 32'd1);
        tick();
        bus_idle();
        tick();
        start_rd(32'h0000_0004);
        tick();
        reg_rvalid = 1'b1;
        reg_rdata  = 32'h0000_00AA;
        tick();
        reg_rvalid = 1'b0;
        chk("to_ok_data", bus.epc_data_o, 32'h0000_00AA);
        chk("to_sticky",  32'(timeout_err), 32'd1);
        tick();
        bus_idle();
        tick();
`else
        // Without the timeout a read waits indefinitely for rvalid.
        r0 = n_rdy;
        start_rd(32'h0000_0000);
        tick();
        repeat (300) tick();
        chk("nto_rdy", 32'(n_rdy - r0), 32'd0);
        chk("nto_err", 32'(timeout_err), 32'd0);
        reg_rvalid = 1'b1;
        reg_rdata  = 32'h0000_0077;
        tick();
        reg_rvalid = 1'b0;
        chk("nto_done", 32'(bus.epc_rdy), 32'd1);
        chk("nto_data", bus.epc_data_o, 32'h0000_0077);
        tick();
        bus_idle();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
